// File: rtl/ddr_test_pkg.sv
// Shared types and constants for the DDR3 self-test pattern generator/checker.
package ddr_test_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam logic [1:0] PAT_INCR  = 2'd0;
    localparam logic [1:0] PAT_WALK  = 2'd1;
    localparam logic [1:0] PAT_PRBS  = 2'd2;
    localparam logic [1:0] PAT_CHECK = 2'd3;

    // Checkerboard word: 0xA... for even slots, 0x5... for odd slots; callers truncate to width.
    function automatic logic [63:0] checker_word(input logic odd);
        return odd ? {16{4'h5}} : {16{4'hA}};
    endfunction

    // Galois LFSR feedback masks (right-shifting form). Widths not listed fall back to a
    // two-tap mask that is not guaranteed maximal length.
    function automatic logic [63:0] prbs_taps(input int w);
        case (w)
            8:       return 64'h0000_0000_0000_00B8;
            16:      return 64'h0000_0000_0000_B400;
            24:      return 64'h0000_0000_00E1_0000;
            32:      return 64'h0000_0000_A300_0000;
            64:      return 64'hD800_0000_0000_0000;
            default: return 64'h3 << (w - 2);
        endcase
    endfunction

endpackage

// File: rtl/ddr_test_pgen_pat_gen.sv
// Pattern generator: one word per index, restarted by load at the start of each pass.
module ddr_pat_gen
    import ddr_test_pkg::*;
#(
    parameter int         DATA_W    = 16,
    parameter logic [15:0] PRBS_SEED = 16'hACE1
) (
    input  logic              clk_50m,
    input  logic              rst,
    input  logic              load,
    input  logic              adv,
    input  logic [1:0]        mode,
    input  logic [15:0]       pass,
    output logic [DATA_W-1:0] data
);
    localparam logic [DATA_W-1:0] TAPS    = DATA_W'(prbs_taps(DATA_W));
    localparam logic [DATA_W-1:0] CB_EVEN = DATA_W'(checker_word(1'b0));
    localparam logic [DATA_W-1:0] CB_ODD  = DATA_W'(checker_word(1'b1));
    localparam logic [DATA_W-1:0] SEED    = DATA_W'(PRBS_SEED);

    logic [DATA_W-1:0] cnt_q, cnt_d, oh_q, oh_d, lfsr_q, lfsr_d, seed_ld;
    logic              odd_q, odd_d, inv_q, inv_d;
    int                rot;

    // Next generator state: load restarts at index 0 for pass p, adv steps one index.
    always_comb begin
        cnt_d   = cnt_q;
        oh_d    = oh_q;
        lfsr_d  = lfsr_q;
        odd_d   = odd_q;
        inv_d   = inv_q;
        rot     = int'(pass) % DATA_W;
        seed_ld = SEED ^ DATA_W'(pass);
        if (seed_ld == '0) begin
            seed_ld = DATA_W'(1);
        end
        if (load) begin
            cnt_d  = DATA_W'(pass);
            oh_d   = DATA_W'(1) << rot;
            lfsr_d = seed_ld;
            odd_d  = 1'b0;
            inv_d  = pass[0];
        end else if (adv) begin
            cnt_d  = cnt_q + DATA_W'(1);
            oh_d   = {oh_q[DATA_W-2:0], oh_q[DATA_W-1]};
            lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
            odd_d  = ~odd_q;
        end
    end

    // Generator state registers.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            cnt_q  <= '0;
            oh_q   <= '0;
            lfsr_q <= '0;
            odd_q  <= 1'b0;
            inv_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            oh_q   <= oh_d;
            lfsr_q <= lfsr_d;
            odd_q  <= odd_d;
            inv_q  <= inv_d;
        end
    end

    // Select the current word for the latched pattern mode.
    always_comb begin
        data = cnt_q;
        case (mode)
            PAT_INCR:  data = cnt_q;
            PAT_WALK:  data = oh_q;
            PAT_PRBS:  data = lfsr_q;
            default:   data = (odd_q ^ inv_q) ? CB_ODD : CB_EVEN;
        endcase
    end

endmodule

// File: rtl/ddr_test_pgen.sv
// DDR3 self-test: write data_max pattern words, read them back, compare and keep error statistics.
//
//  state | meaning
//  IDLE  | waiting for synchronised init_done
//  WRITE | issuing write requests for indices 0..data_max-1
//  READ  | issuing read requests; returned words are checked
//  DRAIN | all reads issued, checking the remaining returned words
//  DONE  | pass complete; loops back to WRITE when loop_en
module ddr_test_pgen
    import ddr_test_pkg::*;
#(
    parameter int          DATA_W    = 16,
    parameter int          CNT_W     = 28,
    parameter int          ERRC_W    = 16,
    parameter logic [15:0] PRBS_SEED = 16'hACE1
) (
    input  logic              clk_50m,
    input  logic              rst,
    input  logic              ddr3_init_done,
    input  logic [CNT_W-1:0]  data_max,
    input  logic [1:0]        pat_mode,
    input  logic              loop_en,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ready,
    output logic              rd_en,
    input  logic              rd_ready,
    input  logic              rd_data_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              error_flag,
    output logic [ERRC_W-1:0] err_cnt,
    output logic [CNT_W-1:0]  first_err_idx,
    output logic [15:0]       pass_cnt
);
    state_e              state_q, state_d;
    logic                init_s1_q, init_s2_q;
    logic [CNT_W-1:0]    wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d, chk_idx_q, chk_idx_d;
    logic [CNT_W-1:0]    max_q, max_d, first_err_q, first_err_d, last_idx;
    logic [1:0]          mode_q, mode_d;
    logic [15:0]         pass_q, pass_d;
    logic                err_flag_q, err_flag_d;
    logic [ERRC_W-1:0]   err_cnt_q, err_cnt_d;
    logic                gen_load, wr_adv, chk_adv, start, abort, chk_vld;
    logic [DATA_W-1:0]   chk_data;

    ddr_pat_gen #(.DATA_W(DATA_W), .PRBS_SEED(PRBS_SEED)) u_wr_gen (
        .clk_50m(clk_50m), .rst(rst), .load(gen_load), .adv(wr_adv),
        .mode(mode_q), .pass(pass_q), .data(wr_data)
    );

    ddr_pat_gen #(.DATA_W(DATA_W), .PRBS_SEED(PRBS_SEED)) u_chk_gen (
        .clk_50m(clk_50m), .rst(rst), .load(gen_load), .adv(chk_adv),
        .mode(mode_q), .pass(pass_q), .data(chk_data)
    );

    // Next-state, index and error-statistics logic.
    always_comb begin
        state_d     = state_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        chk_idx_d   = chk_idx_q;
        max_d       = max_q;
        mode_d      = mode_q;
        pass_d      = pass_q;
        err_flag_d  = err_flag_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        gen_load    = 1'b0;
        wr_adv      = 1'b0;
        chk_adv     = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        last_idx    = max_q - CNT_W'(1);
        chk_vld     = ((state_q == READ) || (state_q == DRAIN)) && rd_data_valid;

        if (chk_vld && (rd_data != chk_data)) begin
            err_flag_d = 1'b1;
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + ERRC_W'(1);
            end
            if (!err_flag_q) begin
                first_err_d = chk_idx_q;
            end
        end

        case (state_q)
            IDLE: begin
                if (init_s2_q) start = 1'b1;
            end
            WRITE: begin
                if (!init_s2_q) begin
                    abort = 1'b1;
                end else if (wr_ready) begin
                    wr_idx_d = wr_idx_q + CNT_W'(1);
                    wr_adv   = 1'b1;
                    if (wr_idx_q == last_idx) state_d = READ;
                end
            end
            READ, DRAIN: begin
                if (!init_s2_q) begin
                    abort = 1'b1;
                end else begin
                    if ((state_q == READ) && rd_ready) begin
                        rd_idx_d = rd_idx_q + CNT_W'(1);
                        if (rd_idx_q == last_idx) state_d = DRAIN;
                    end
                    if (chk_vld) begin
                        chk_idx_d = chk_idx_q + CNT_W'(1);
                        chk_adv   = 1'b1;
                        if (chk_idx_q == last_idx) begin
                            state_d = DONE;
                            pass_d  = pass_q + 16'd1;
                        end
                    end
                end
            end
            DONE: begin
                if (!init_s2_q)   state_d = IDLE;
                else if (loop_en) start   = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            max_d     = data_max;
            mode_d    = pat_mode;
            wr_idx_d  = '0;
            rd_idx_d  = '0;
            chk_idx_d = '0;
            gen_load  = 1'b1;
            if (data_max == '0) begin
                state_d = DONE;
                pass_d  = pass_q + 16'd1;
            end else begin
                state_d = WRITE;
            end
        end

        if (abort) begin
            state_d   = IDLE;
            wr_idx_d  = '0;
            rd_idx_d  = '0;
            chk_idx_d = '0;
        end
    end

    // State, synchroniser and statistics registers.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state_q     <= IDLE;
            init_s1_q   <= 1'b0;
            init_s2_q   <= 1'b0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            chk_idx_q   <= '0;
            max_q       <= '0;
            mode_q      <= '0;
            pass_q      <= '0;
            err_flag_q  <= 1'b0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
        end else begin
            state_q     <= state_d;
            init_s1_q   <= ddr3_init_done;
            init_s2_q   <= init_s1_q;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            chk_idx_q   <= chk_idx_d;
            max_q       <= max_d;
            mode_q      <= mode_d;
            pass_q      <= pass_d;
            err_flag_q  <= err_flag_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
        end
    end

    // Outputs decoded from the current state.
    always_comb begin
        wr_en         = (state_q == WRITE);
        rd_en         = (state_q == READ);
        busy          = (state_q == WRITE) || (state_q == READ) || (state_q == DRAIN);
        done          = (state_q == DONE);
        error_flag    = err_flag_q;
        err_cnt       = err_cnt_q;
        first_err_idx = first_err_q;
        pass_cnt      = pass_q;
    end

endmodule

// File: tb/tb_ddr_test_pgen.sv
// Self-checking bench: randomised DDR3 memory model with backpressure and variable read latency.
module tb_ddr_test_pgen;

    logic        clk_50m = 1'b0;
    logic        rst = 1'b1;
    logic        ddr3_init_done = 1'b0;
    logic [27:0] data_max = '0;
    logic [1:0]  pat_mode = '0;
    logic        loop_en = 1'b0;
    logic        wr_en, rd_en, busy, done, error_flag;
    logic [15:0] wr_data, rd_data = '0;
    logic        wr_ready = 1'b0, rd_ready = 1'b0, rd_data_valid = 1'b0;
    logic [15:0] err_cnt, pass_cnt;
    logic [27:0] first_err_idx;

    int n_pass = 0;
    int n_total = 0;

    // memory model state
    typedef struct { int due; logic [15:0] d; } rd_t;
    rd_t         rq[$];
    logic [15:0] wr_log[$];
    logic [15:0] mem[0:255];
    int          cyc = 0, wr_cnt = 0, rd_cnt = 0, last_due = 0;
    int          lat_min = 3, lat_max = 3;
    bit          rand_ready = 0, corrupt = 0, saw_en = 0;

    ddr_test_pgen #(.DATA_W(16), .CNT_W(28), .ERRC_W(16), .PRBS_SEED(16'hACE1)) dut (
        .clk_50m(clk_50m), .rst(rst), .ddr3_init_done(ddr3_init_done),
        .data_max(data_max), .pat_mode(pat_mode), .loop_en(loop_en),
        .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_en(rd_en), .rd_ready(rd_ready), .rd_data_valid(rd_data_valid), .rd_data(rd_data),
        .busy(busy), .done(done), .error_flag(error_flag), .err_cnt(err_cnt),
        .first_err_idx(first_err_idx), .pass_cnt(pass_cnt)
    );

    always #5 clk_50m = ~clk_50m;

    // Memory responder: decides handshakes for the coming rising edge and returns reads in order.
    always @(negedge clk_50m) begin
        logic [15:0] d;
        int due;
        cyc++;
        wr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        rd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (wr_en || rd_en) saw_en = 1;
        if (wr_en && wr_ready) begin
            mem[wr_cnt % 256] = wr_data;
            wr_log.push_back(wr_data);
            wr_cnt++;
        end
        if (rd_en && rd_ready) begin
            d = mem[rd_cnt % 256];
            if (corrupt && (rd_cnt == 5 || rd_cnt == 9)) d = d ^ 16'h0008;
            due = cyc + $urandom_range(lat_min, lat_max);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            rq.push_back('{due, d});
            rd_cnt++;
        end
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            rd_data_valid = 1'b1;
            rd_data = rq[0].d;
            void'(rq.pop_front());
        end else begin
            rd_data_valid = 1'b0;
            rd_data = 16'($urandom);
        end
    end

    // Reference pattern word for mode m, pass p, index i.
    function automatic logic [15:0] exp_word(int m, int p, int i);
        logic [15:0] x;
        case (m)
            0: return 16'((i + p) % 65536);
            1: return 16'(1) << ((i + p) % 16);
            2: begin
                x = 16'hACE1 ^ 16'(p);
                if (x == 16'h0) x = 16'h1;
                for (int k = 0; k < i; k++) x = x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
                return x;
            end
            default: begin
                x = (i % 2 == 0) ? 16'hAAAA : 16'h5555;
                if (p % 2 == 1) x = ~x;
                return x;
            end
        endcase
    endfunction

    task automatic clear_model();
        rq.delete();
        wr_log.delete();
        wr_cnt = 0;
        rd_cnt = 0;
        last_due = cyc;
        saw_en = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ddr3_init_done = 1'b0;
        loop_en = 1'b0;
        rand_ready = 0;
        corrupt = 0;
        lat_min = 3;
        lat_max = 3;
        repeat (3) @(posedge clk_50m);
        #1;
        clear_model();
        rst = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk_50m);
            #1;
            if (done) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if ({wr_en, rd_en, busy, done, error_flag} !== 5'b0) $display("FAIL reset_ctrl got=%b want=00000", {wr_en, rd_en, busy, done, error_flag});
        else n_pass++;
        n_total++;
        if (err_cnt !== 16'd0 || first_err_idx !== 28'd0 || pass_cnt !== 16'd0)
            $display("FAIL reset_stats got err_cnt=%0d first=%0d pass=%0d want 0", err_cnt, first_err_idx, pass_cnt);
        else n_pass++;
        n_total++;
        if (wr_data !== 16'd0) $display("FAIL reset_wr_data got=%h want=0000", wr_data);
        else n_pass++;
    endtask

    task automatic test_incr();
        bit ok;
        do_reset();
        data_max = 28'd8;
        pat_mode = 2'd0;
        ddr3_init_done = 1'b1;
        wait_done(400, ok);
        n_total++;
        if (!ok) $display("FAIL incr_done timeout got=0 want=1");
        else n_pass++;
        n_total++;
        if (wr_log.size() != 8) $display("FAIL incr_wr_count got=%0d want=8", wr_log.size());
        else n_pass++;
        for (int i = 0; i < wr_log.size() && i < 8; i++) begin
            n_total++;
            if (wr_log[i] !== exp_word(0, 0, i)) $display("FAIL incr_word%0d got=%h want=%h", i, wr_log[i], exp_word(0, 0, i));
            else n_pass++;
        end
        n_total++;
        if (rd_cnt != 8 || error_flag !== 1'b0 || pass_cnt !== 16'd1)
            $display("FAIL incr_status got rd=%0d err=%b pass=%0d want rd=8 err=0 pass=1", rd_cnt, error_flag, pass_cnt);
        else n_pass++;
    endtask

    task automatic test_prbs_backpressure();
        bit ok;
        int bad;
        do_reset();
        rand_ready = 1;
        lat_min = 1;
        lat_max = 10;
        data_max = 28'd100;
        pat_mode = 2'd2;
        ddr3_init_done = 1'b1;
        wait_done(6000, ok);
        n_total++;
        if (!ok) $display("FAIL prbs_done timeout got=0 want=1");
        else n_pass++;
        n_total++;
        if (wr_log.size() != 100 || rd_cnt != 100)
            $display("FAIL prbs_counts got wr=%0d rd=%0d want 100/100", wr_log.size(), rd_cnt);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < wr_log.size(); i++) begin
            if (wr_log[i] !== exp_word(2, 0, i)) begin
                if (bad == 0) $display("FAIL prbs_word%0d got=%h want=%h", i, wr_log[i], exp_word(2, 0, i));
                bad++;
            end
        end
        n_total++;
        if (bad == 0) n_pass++;
        n_total++;
        if (error_flag !== 1'b0 || err_cnt !== 16'd0)
            $display("FAIL prbs_errors got flag=%b cnt=%0d want 0/0", error_flag, err_cnt);
        else n_pass++;
    endtask

    task automatic test_errors();
        bit ok;
        do_reset();
        corrupt = 1;
        lat_min = 1;
        lat_max = 5;
        data_max = 28'd16;
        pat_mode = 2'd1;
        ddr3_init_done = 1'b1;
        wait_done(600, ok);
        n_total++;
        if (!ok) $display("FAIL err_done timeout got=0 want=1");
        else n_pass++;
        n_total++;
        if (wr_log.size() != 16 || wr_log[3] !== exp_word(1, 0, 3))
            $display("FAIL err_walk got n=%0d w3=%h want n=16 w3=%h", wr_log.size(), wr_log[3], exp_word(1, 0, 3));
        else n_pass++;
        n_total++;
        if (error_flag !== 1'b1 || err_cnt !== 16'd2 || first_err_idx !== 28'd5)
            $display("FAIL err_stats got flag=%b cnt=%0d first=%0d want 1/2/5", error_flag, err_cnt, first_err_idx);
        else n_pass++;
    endtask

    task automatic test_zero();
        bit ok;
        do_reset();
        data_max = 28'd0;
        pat_mode = 2'd0;
        ddr3_init_done = 1'b1;
        wait_done(50, ok);
        n_total++;
        if (!ok) $display("FAIL zero_done timeout got=0 want=1");
        else n_pass++;
        repeat (5) @(posedge clk_50m);
        #1;
        n_total++;
        if (saw_en || wr_cnt != 0 || rd_cnt != 0 || busy !== 1'b0)
            $display("FAIL zero_traffic got en=%0d wr=%0d rd=%0d busy=%b want none", saw_en, wr_cnt, rd_cnt, busy);
        else n_pass++;
        n_total++;
        if (done !== 1'b1 || pass_cnt !== 16'd1) $display("FAIL zero_pass got done=%b pass=%0d want 1/1", done, pass_cnt);
        else n_pass++;
    endtask

    task automatic test_loop();
        bit ok;
        int bad;
        do_reset();
        lat_min = 2;
        lat_max = 2;
        data_max = 28'd4;
        pat_mode = 2'd3;
        loop_en = 1'b1;
        ddr3_init_done = 1'b1;
        ok = 0;
        for (int k = 0; k < 600; k++) begin
            @(posedge clk_50m);
            #1;
            if (pass_cnt == 16'd3) begin
                ok = 1;
                break;
            end
        end
        loop_en = 1'b0;
        n_total++;
        if (!ok) $display("FAIL loop_passes timeout got=%0d want=3", pass_cnt);
        else n_pass++;
        repeat (10) @(posedge clk_50m);
        #1;
        n_total++;
        if (wr_log.size() != 12 || pass_cnt !== 16'd3 || done !== 1'b1)
            $display("FAIL loop_stop got wr=%0d pass=%0d done=%b want 12/3/1", wr_log.size(), pass_cnt, done);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < wr_log.size(); i++) begin
            if (wr_log[i] !== exp_word(3, i / 4, i % 4)) begin
                if (bad == 0) $display("FAIL loop_word%0d got=%h want=%h", i, wr_log[i], exp_word(3, i / 4, i % 4));
                bad++;
            end
        end
        n_total++;
        if (bad == 0) n_pass++;
    endtask

    task automatic test_abort();
        bit ok;
        int k;
        do_reset();
        corrupt = 1;
        data_max = 28'd16;
        pat_mode = 2'd0;
        ddr3_init_done = 1'b1;
        wait_done(600, ok);
        n_total++;
        if (!ok || err_cnt !== 16'd2 || pass_cnt !== 16'd1)
            $display("FAIL abort_setup got ok=%0d cnt=%0d pass=%0d want 1/2/1", ok, err_cnt, pass_cnt);
        else n_pass++;
        corrupt = 0;
        ddr3_init_done = 1'b0;
        repeat (6) @(posedge clk_50m);
        #1;
        clear_model();
        ddr3_init_done = 1'b1;
        ok = 0;
        for (int j = 0; j < 200; j++) begin
            @(posedge clk_50m);
            #1;
            if (rd_en) begin
                ok = 1;
                break;
            end
        end
        n_total++;
        if (!ok) $display("FAIL abort_reach_read timeout got=0 want=1");
        else n_pass++;
        repeat (2) @(posedge clk_50m);
        #1;
        ddr3_init_done = 1'b0;
        k = 0;
        for (int j = 1; j <= 8; j++) begin
            @(posedge clk_50m);
            #1;
            if (!busy && !rd_en) begin
                k = j;
                break;
            end
        end
        n_total++;
        if (k == 0 || k > 3) $display("FAIL abort_latency got=%0d cycles want<=3", k);
        else n_pass++;
        n_total++;
        if (error_flag !== 1'b1 || err_cnt !== 16'd2 || first_err_idx !== 28'd5 || pass_cnt !== 16'd1)
            $display("FAIL abort_kept got flag=%b cnt=%0d first=%0d pass=%0d want 1/2/5/1", error_flag, err_cnt, first_err_idx, pass_cnt);
        else n_pass++;
        repeat (15) @(posedge clk_50m);
        #1;
        clear_model();
        ddr3_init_done = 1'b1;
        wait_done(600, ok);
        n_total++;
        if (!ok || wr_log.size() != 16 || rd_cnt != 16)
            $display("FAIL abort_restart got ok=%0d wr=%0d rd=%0d want 1/16/16", ok, wr_log.size(), rd_cnt);
        else n_pass++;
        n_total++;
        if (wr_log.size() == 0 || wr_log[0] !== exp_word(0, 1, 0) || err_cnt !== 16'd2 || pass_cnt !== 16'd2)
            $display("FAIL abort_fresh got w0=%h cnt=%0d pass=%0d want w0=%h cnt=2 pass=2",
                     (wr_log.size() > 0) ? wr_log[0] : 16'hxxxx, err_cnt, pass_cnt, exp_word(0, 1, 0));
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_incr();
        test_prbs_backpressure();
        test_errors();
        test_zero();
        test_loop();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
